// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keystroke injector.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        E0_MK,
        MAKE,
        HOLD,
        E0_BK,
        F0,
        BREAK
    } state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam int         FRAME_BITS = 11;

    // Counter width able to hold 0..n-1, never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_key_injector_if.sv
// Key request handshake between a key source and the injector.
interface ps2_key_injector_if;

    logic       KEY_VALID;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED;
    logic       KEY_READY;

    modport master (
        output KEY_VALID,
        output KEY_CODE,
        output KEY_EXTENDED,
        input  KEY_READY
    );

    modport slave (
        input  KEY_VALID,
        input  KEY_CODE,
        input  KEY_EXTENDED,
        output KEY_READY
    );

endinterface

// File: rtl/ps2_frame_tx.sv
// Serialises one byte as an 11-bit device-to-host PS/2 frame plus idle gap.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 1024,
    parameter int GAP_CYCLES = 2048
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA,
    output logic       DONE,
    output logic       PS2_CLK,
    output logic       PS2_DATA
);

    localparam int HW = cnt_w(CLK_DIV);
    localparam int GW = cnt_w(GAP_CYCLES + 1);
    localparam int PW = $clog2(2 * FRAME_BITS + 1);

    localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * FRAME_BITS - 1);

    logic          active;
    logic          in_gap;
    logic [HW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] phase;
    logic [9:0]    shreg;

    assign DONE = in_gap && (gap_cnt == GAP_END);

    // Even phases hold PS2_CLK high, odd phases low; data moves on odd->even.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            active   <= 1'b0;
            in_gap   <= 1'b0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            phase    <= '0;
            shreg    <= '1;
            PS2_CLK  <= 1'b1;
            PS2_DATA <= 1'b1;
        end else if (START && (!active || DONE)) begin
            active   <= 1'b1;
            in_gap   <= 1'b0;
            half_cnt <= '0;
            gap_cnt  <= '0;
            phase    <= '0;
            shreg    <= {1'b1, ~^DATA, DATA};
            PS2_CLK  <= 1'b1;
            PS2_DATA <= 1'b0;
        end else if (in_gap) begin
            if (DONE) begin
                active  <= 1'b0;
                in_gap  <= 1'b0;
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end else if (active) begin
            if (half_cnt == HALF_END) begin
                half_cnt <= '0;
                phase    <= phase + 1'b1;
                if (!phase[0]) begin
                    PS2_CLK <= 1'b0;
                end else begin
                    PS2_CLK  <= 1'b1;
                    PS2_DATA <= shreg[0];
                    shreg    <= {1'b1, shreg[9:1]};
                    if (phase == PH_LAST) begin
                        in_gap   <= 1'b1;
                        PS2_DATA <= 1'b1;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_injector.sv
// PS/2 keyboard emulator: types make, waits VSYNC frames, then types break.
module ps2_key_injector
    import ps2_pkg::*;
#(
    parameter int CLK_DIV     = 1024,
    parameter int GAP_CYCLES  = 2048,
    parameter int HOLD_FRAMES = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    ps2_key_injector_if.slave  key,
    input  logic               VSYNC,
    output logic               PS2_CLK,
    output logic               PS2_DATA,
    output logic               BUSY
);

    localparam int HW = cnt_w(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_N = HW'(HOLD_FRAMES);

    state_t        state;
    logic [7:0]    code;
    logic          ext;
    logic [2:0]    vs_sync;
    logic [HW-1:0] hold_cnt;
    logic          vs_rise;
    logic          hold_exit;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_done;

    assign vs_rise   = vs_sync[1] & ~vs_sync[2];
    assign hold_exit = (state == HOLD) && (hold_cnt == HOLD_N);
    assign BUSY      = ~key.KEY_READY;

    // Next frame launches on the same edge as the state change, so frames chain.
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = code;
        unique case (state)
            IDLE: begin
                tx_start = key.KEY_VALID & key.KEY_READY;
                tx_byte  = key.KEY_EXTENDED ? PS2_EXT : key.KEY_CODE;
            end
            E0_MK: tx_start = tx_done;
            HOLD: begin
                tx_start = hold_exit;
                tx_byte  = ext ? PS2_EXT : PS2_BREAK;
            end
            E0_BK: begin
                tx_start = tx_done;
                tx_byte  = PS2_BREAK;
            end
            F0: tx_start = tx_done;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            code          <= '0;
            ext           <= 1'b0;
            vs_sync       <= '0;
            hold_cnt      <= '0;
            key.KEY_READY <= 1'b1;
        end else begin
            vs_sync <= {vs_sync[1:0], VSYNC};
            unique case (state)
                IDLE: begin
                    if (key.KEY_VALID && key.KEY_READY) begin
                        code          <= key.KEY_CODE;
                        ext           <= key.KEY_EXTENDED;
                        key.KEY_READY <= 1'b0;
                        state <= key.KEY_EXTENDED ? E0_MK : MAKE;
                    end
                end
                E0_MK: if (tx_done) state <= MAKE;
                MAKE: begin
                    if (tx_done) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (hold_exit) begin
                        state <= ext ? E0_BK : F0;
                    end else if (vs_rise) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                E0_BK: if (tx_done) state <= F0;
                F0:    if (tx_done) state <= BREAK;
                BREAK: begin
                    if (tx_done) begin
                        state         <= IDLE;
                        key.KEY_READY <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ps2_frame_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_tx (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (tx_start),
        .DATA     (tx_byte),
        .DONE     (tx_done),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA)
    );

endmodule
